mips_prog_loader: RTL and testbench

MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

---
 rtl/mips_prog_loader.sv | 172 +++++++++++++++++
 tb/tb_mips_prog_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_prog_loader.sv
// rtl/mips_prog_loader.sv - serial byte-stream program loader for a mips32 core's instruction memory
// Optional trailing XOR checksum byte is enabled by defining MIPS_LOADER_CHECKSUM_EN.
module mips_prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              load_req,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, CHK, FINISH, ERR
  } state_t;

  localparam logic [31:0]     MAX_WORDS = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_len_hi;
  logic [ADDR_W:0]     r_nwords;
  logic [1:0]          r_byte_cnt;
  logic [23:0]         r_shift;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_cpu_hold;
  logic                r_cpu_start;
  logic                r_done;
  logic                r_err;
  logic [ADDR_W:0]     r_word_count;
`ifdef MIPS_LOADER_CHECKSUM_EN
  logic [7:0]          r_xor;
`endif

  logic        w_in_ready;
  logic        w_busy;
  logic        w_accept;
  logic        w_start_session;
  logic [15:0] w_len;
  logic        w_len_bad;
  logic        w_word_end;
  logic        w_last_word;

  assign w_in_ready      = (r_state == LEN_HI) || (r_state == LEN_LO) ||
                           (r_state == DATA)   || (r_state == CHK);
  assign w_busy          = w_in_ready || (r_state == FINISH);
  assign w_accept        = in_valid && w_in_ready;
  assign w_start_session = load_req && ((r_state == IDLE) || (r_state == ERR));
  assign w_len           = {r_len_hi, in_data};
  assign w_len_bad       = (w_len == 16'd0) || ({16'd0, w_len} > MAX_WORDS);
  assign w_word_end      = (r_byte_cnt == 2'd3);
  assign w_last_word     = ((r_word_count + ONE_WORD) == r_nwords);

  always_ff @(posedge clk1) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, ERR: if (w_start_session) w_state_nxt = LEN_HI;
      LEN_HI:    if (w_accept) w_state_nxt = LEN_LO;
      LEN_LO:    if (w_accept) w_state_nxt = w_len_bad ? ERR : DATA;
      DATA: begin
        if (w_accept && w_word_end && w_last_word) begin
`ifdef MIPS_LOADER_CHECKSUM_EN
          w_state_nxt = CHK;
`else
          w_state_nxt = FINISH;
`endif
        end
      end
`ifdef MIPS_LOADER_CHECKSUM_EN
      CHK:       if (w_accept) w_state_nxt = (in_data == r_xor) ? FINISH : ERR;
`endif
      FINISH:    w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Datapath: a word is committed the cycle after its 4th byte, so the write
  // of word k overlaps the byte stream of word k+1 without stalling.
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_len_hi     <= '0;
      r_nwords     <= '0;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_hold   <= 1'b1;
      r_cpu_start  <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_word_count <= '0;
`ifdef MIPS_LOADER_CHECKSUM_EN
      r_xor        <= '0;
`endif
    end else begin
      r_mem_we    <= 1'b0;
      r_cpu_start <= 1'b0;
      if (w_start_session) begin
        r_done       <= 1'b0;
        r_err        <= 1'b0;
        r_word_count <= '0;
        r_cpu_hold   <= 1'b1;
        r_byte_cnt   <= '0;
`ifdef MIPS_LOADER_CHECKSUM_EN
        r_xor        <= '0;
`endif
      end
      if (w_accept) begin
        case (r_state)
          LEN_HI: r_len_hi <= in_data;
          LEN_LO: begin
            r_nwords <= w_len[ADDR_W:0];
            if (w_len_bad) r_err <= 1'b1;
          end
          DATA: begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {r_shift[15:0], in_data};
`ifdef MIPS_LOADER_CHECKSUM_EN
            r_xor      <= r_xor ^ in_data;
`endif
            if (w_word_end) begin
              r_mem_we     <= 1'b1;
              r_mem_addr   <= r_word_count[ADDR_W-1:0];
              r_mem_wdata  <= {r_shift, in_data};
              r_word_count <= r_word_count + ONE_WORD;
            end
          end
`ifdef MIPS_LOADER_CHECKSUM_EN
          CHK: if (in_data != r_xor) r_err <= 1'b1;
`endif
          default: ;
        endcase
      end
      if (r_state == FINISH) begin
        r_cpu_hold  <= 1'b0;
        r_cpu_start <= 1'b1;
        r_done      <= 1'b1;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign busy       = w_busy;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_hold   = r_cpu_hold;
  assign cpu_start  = r_cpu_start;
  assign done       = r_done;
  assign err        = r_err;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_mips_prog_loader.sv
// tb/tb_mips_prog_loader.sv - directed self-checking bench for mips_prog_loader
// Builds with or without MIPS_LOADER_CHECKSUM_EN; checksum scenarios run only when it is defined.
module tb_mips_prog_loader;
  localparam int ADDR_W = 10;

  logic              clk1 = 1'b0;
  logic              reset;
  logic              load_req;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              cpu_start;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;

  mips_prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk1(clk1), .reset(reset), .load_req(load_req),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .cpu_start(cpu_start), .busy(busy),
    .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk1 = ~clk1;

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  logic [ADDR_W:0]   wr_wc[$];
  logic [31:0]       prog[0:15];

  always @(negedge clk1) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_wc.push_back(word_count);
    end
    if (cpu_start) n_start <= n_start + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] prog_byte(input int k);
    logic [31:0] w;
    w = prog[k / 4];
    return w[31 - 8 * (k % 4) -: 8];
  endfunction

  function automatic logic [7:0] prog_xor(input int n);
    logic [7:0] x = 8'h00;
    for (int k = 0; k < 4 * n; k++) x = x ^ prog_byte(k);
    return x;
  endfunction

  task automatic start_load();
    @(negedge clk1);
    load_req = 1'b1;
    in_valid = 1'b0;
    @(posedge clk1);
    #1 load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    if (gap > 0) begin
      @(negedge clk1);
      in_valid = 1'b0;
      repeat (gap - 1) @(negedge clk1);
    end
    @(negedge clk1);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 50) begin
      @(negedge clk1);
      t++;
    end
    if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk1);
  endtask

  task automatic wait_end();
    int t = 0;
    @(negedge clk1);
    in_valid = 1'b0;
    while (busy && t < 40) begin
      @(negedge clk1);
      t++;
    end
    check("session_end", 32'(busy), 32'd0);
    repeat (2) @(negedge clk1);
  endtask

  task automatic load_prog(input int n, input int max_gap);
    logic [15:0] len;
    len = 16'(n);
    start_load();
    send_byte(len[15:8], 0);
    send_byte(len[7:0], max_gap > 0 ? int'($urandom_range(0, max_gap)) : 0);
    for (int k = 0; k < 4 * n; k++)
      send_byte(prog_byte(k), max_gap > 0 ? int'($urandom_range(0, max_gap)) : 0);
`ifdef MIPS_LOADER_CHECKSUM_EN
    send_byte(prog_xor(n), 0);
`endif
    wait_end();
  endtask

  task automatic check_writes(input string tag, input int base, input int n);
    int got_n;
    got_n = wr_addr.size() - base;
    check({tag, "_nwrites"}, 32'(got_n), 32'(n));
    for (int i = 0; i < n && i < got_n; i++) begin
      check({tag, "_addr"}, 32'(wr_addr[base + i]), 32'(i));
      check({tag, "_data"}, wr_data[base + i], prog[i]);
      check({tag, "_wc"}, 32'(wr_wc[base + i]), 32'(i + 1));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},   32'(in_ready),   32'd0);
    check({tag, "_mem_we"},     32'(mem_we),     32'd0);
    check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    check({tag, "_mem_wdata"},  mem_wdata,       32'd0);
    check({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
    check({tag, "_cpu_start"},  32'(cpu_start),  32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_err"},        32'(err),        32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  task automatic check_ok_end(input string tag, input int n, input int sbase);
    check({tag, "_word_count"}, 32'(word_count), 32'(n));
    check({tag, "_starts"},     32'(n_start - sbase), 32'd1);
    check({tag, "_done"},       32'(done),     32'd1);
    check({tag, "_err"},        32'(err),      32'd0);
    check({tag, "_cpu_hold"},   32'(cpu_hold), 32'd0);
  endtask

  task automatic bad_len(input string tag, input logic [7:0] hi, input logic [7:0] lo);
    int base, sbase;
    base  = wr_addr.size();
    sbase = n_start;
    start_load();
    send_byte(hi, 0);
    send_byte(lo, 0);
    wait_end();
    check({tag, "_err"},      32'(err),      32'd1);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_nwrites"},  32'(wr_addr.size() - base), 32'd0);
    check({tag, "_starts"},   32'(n_start - sbase), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int base, sbase;
    reset    = 1'b1;
    load_req = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk1);
    #1 reset = 1'b0;
    @(negedge clk1);
    check_reset_vals("rst");

    // two-word program, back-to-back bytes
    prog[0] = 32'h2801000A;
    prog[1] = 32'h28020014;
    base  = wr_addr.size();
    sbase = n_start;
    load_prog(2, 0);
    check_writes("two", base, 2);
    check_ok_end("two", 2, sbase);

    // nine-word program with random valid gaps
    prog[0] = 32'h20080005; prog[1] = 32'h20090003; prog[2] = 32'h01095020;
    prog[3] = 32'h01095822; prog[4] = 32'hAC0A0000; prog[5] = 32'h8C0C0000;
    prog[6] = 32'h11800001; prog[7] = 32'h200D0001; prog[8] = 32'hFC000000;
    base  = wr_addr.size();
    sbase = n_start;
    load_prog(9, 3);
    check_writes("nine", base, 9);
    check_ok_end("nine", 9, sbase);

    bad_len("len0", 8'h00, 8'h00);
    bad_len("len1025", 8'h04, 8'h01);

    // reset after 6 data bytes; load_req held with reset must be ignored
    prog[0] = 32'h2801000A;
    prog[1] = 32'h28020014;
    prog[2] = 32'h00000000;
    base = wr_addr.size();
    start_load();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    for (int k = 0; k < 6; k++) send_byte(prog_byte(k), 0);
    @(negedge clk1);
    reset    = 1'b1;
    load_req = 1'b1;
    @(posedge clk1);
    #1 reset = 1'b0;
    load_req = 1'b0;
    in_valid = 1'b0;
    @(negedge clk1);
    check_reset_vals("midrst");
    repeat (4) @(negedge clk1);
    check_writes("midrst", base, 1);
    base  = wr_addr.size();
    sbase = n_start;
    load_prog(2, 0);
    check_writes("after_rst", base, 2);
    check_ok_end("after_rst", 2, sbase);

    // load_req during a session is ignored
    base  = wr_addr.size();
    sbase = n_start;
    start_load();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int k = 0; k < 5; k++) send_byte(prog_byte(k), 0);
    @(negedge clk1);
    in_valid = 1'b0;
    load_req = 1'b1;
    @(posedge clk1);
    #1 load_req = 1'b0;
    @(negedge clk1);
    check("midreq_wc", 32'(word_count), 32'd1);
    check("midreq_busy", 32'(busy), 32'd1);
    for (int k = 5; k < 8; k++) send_byte(prog_byte(k), 0);
`ifdef MIPS_LOADER_CHECKSUM_EN
    send_byte(prog_xor(2), 0);
`endif
    wait_end();
    check_writes("midreq", base, 2);
    check_ok_end("midreq", 2, sbase);

`ifdef MIPS_LOADER_CHECKSUM_EN
    check("chk_model", 32'(prog_xor(2)), 32'h1D);
    base  = wr_addr.size();
    sbase = n_start;
    start_load();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int k = 0; k < 8; k++) send_byte(prog_byte(k), 0);
    send_byte(8'h1D, 0);
    wait_end();
    check_writes("chk_ok", base, 2);
    check_ok_end("chk_ok", 2, sbase);
    for (int v = 0; v < 2; v++) begin
      base  = wr_addr.size();
      sbase = n_start;
      start_load();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      for (int k = 0; k < 8; k++) send_byte(prog_byte(k), 0);
      send_byte(v == 0 ? 8'h00 : 8'h3F, 0);
      wait_end();
      check_writes("chk_bad", base, 2);
      check("chk_bad_err",    32'(err),      32'd1);
      check("chk_bad_done",   32'(done),     32'd0);
      check("chk_bad_hold",   32'(cpu_hold), 32'd1);
      check("chk_bad_starts", 32'(n_start - sbase), 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
